// File: rtl/amp_frame_scheduler_if.sv
// Bundle of frame, preprocessor and output handshake signals for amp_frame_scheduler.
// slave is the scheduler's view; master is the surrounding environment's view.
interface amp_frame_scheduler_if #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int BIN_QTY = 12
);
  localparam int FW = BIN_QTY * (W + D);
  localparam int SW = W + D + $clog2(BIN_QTY);

  logic [FW-1:0] in_amps_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [FW-1:0] pp_amps_o;
  logic          pp_start_o;
  logic [FW-1:0] pp_amps_i;
  logic [FW-1:0] pp_fast_i;
  logic [SW-1:0] pp_sum_i;
  logic          pp_data_v_i;
  logic [FW-1:0] out_amps_o;
  logic [FW-1:0] out_fast_o;
  logic [SW-1:0] out_sum_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;
  logic          timeout_err_o;
  logic          err_clr_i;
  logic [15:0]   frame_cnt_o;

  modport slave (
    input  in_amps_i, in_valid_i, pp_amps_i, pp_fast_i, pp_sum_i, pp_data_v_i,
           out_ready_i, err_clr_i,
    output in_ready_o, pp_amps_o, pp_start_o, out_amps_o, out_fast_o, out_sum_o,
           out_valid_o, busy_o, timeout_err_o, frame_cnt_o
  );

  modport master (
    output in_amps_i, in_valid_i, pp_amps_i, pp_fast_i, pp_sum_i, pp_data_v_i,
           out_ready_i, err_clr_i,
    input  in_ready_o, pp_amps_o, pp_start_o, out_amps_o, out_fast_o, out_sum_o,
           out_valid_o, busy_o, timeout_err_o, frame_cnt_o
  );
endinterface

// File: rtl/amp_frame_scheduler.sv
// Captures an amplitude frame, launches the preprocessor, waits (bounded) for its result and presents it downstream.
// Optional one-frame input skid buffer enabled by defining AMP_SCHED_SKID_EN.
module amp_frame_scheduler #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int BIN_QTY = 12,
  parameter int TIMEOUT = 8
) (
  input logic                  clk,
  input logic                  rst,
  amp_frame_scheduler_if.slave bus
);
  localparam int FW = BIN_QTY * (W + D);
  localparam int SW = W + D + $clog2(BIN_QTY);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUTPUT} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          start_p0;
  logic          vld_p1;
  logic          err;
  logic [15:0]   frame_cnt;
  logic          in_ready;
  logic          accept;
  logic          frame_load;
  logic          timeout_hit;
  logic [FW-1:0] frame_src;
  logic [FW-1:0] frame_p0;
  logic [FW-1:0] out_amps_p1;
  logic [FW-1:0] out_fast_p1;
  logic [SW-1:0] out_sum_p1;

  // A result arriving on the last allowed WAIT cycle wins over the timeout.
  assign timeout_hit = (state == WAIT) && !bus.pp_data_v_i && (wait_cnt == CW'(TIMEOUT));
  assign accept      = bus.in_valid_i && in_ready;

`ifdef AMP_SCHED_SKID_EN
  logic          skid_full;
  logic          skid_load;
  logic [FW-1:0] skid_p0;

  assign in_ready   = !skid_full;
  assign skid_load  = accept && (state != IDLE);
  assign frame_load = (state == IDLE) && (skid_full || accept);
  assign frame_src  = skid_full ? skid_p0 : bus.in_amps_i;
`else
  assign in_ready   = (state == IDLE);
  assign frame_load = accept;
  assign frame_src  = bus.in_amps_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      start_p0  <= 1'b0;
      vld_p1    <= 1'b0;
      wait_cnt  <= '0;
      err       <= 1'b0;
      frame_cnt <= '0;
`ifdef AMP_SCHED_SKID_EN
      skid_full <= 1'b0;
`endif
    end else begin
      start_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_load) begin
            state    <= LAUNCH;
            start_p0 <= 1'b1;
          end
        end
        LAUNCH: begin
          state    <= WAIT;
          wait_cnt <= CW'(1);
        end
        WAIT: begin
          if (bus.pp_data_v_i) begin
            state    <= OUTPUT;
            vld_p1   <= 1'b1;
            wait_cnt <= '0;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.out_ready_i) begin
            state     <= IDLE;
            vld_p1    <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (timeout_hit) err <= 1'b1;
      else if (bus.err_clr_i) err <= 1'b0;
`ifdef AMP_SCHED_SKID_EN
      if (skid_load) skid_full <= 1'b1;
      else if ((state == IDLE) && skid_full) skid_full <= 1'b0;
`endif
    end
  end

  // p0: captured frame (and skid) / p1: preprocessor results held for downstream
  always_ff @(posedge clk) begin
    if (frame_load) frame_p0 <= frame_src;
`ifdef AMP_SCHED_SKID_EN
    if (skid_load) skid_p0 <= bus.in_amps_i;
`endif
    if ((state == WAIT) && bus.pp_data_v_i) begin
      out_amps_p1 <= bus.pp_amps_i;
      out_fast_p1 <= bus.pp_fast_i;
      out_sum_p1  <= bus.pp_sum_i;
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.pp_amps_o     = frame_p0;
  assign bus.pp_start_o    = start_p0;
  assign bus.out_amps_o    = out_amps_p1;
  assign bus.out_fast_o    = out_fast_p1;
  assign bus.out_sum_o     = out_sum_p1;
  assign bus.out_valid_o   = vld_p1;
  assign bus.busy_o        = (state != IDLE);
  assign bus.timeout_err_o = err;
  assign bus.frame_cnt_o   = frame_cnt;
endmodule

// File: tb/tb_amp_frame_scheduler.sv
// Bench for amp_frame_scheduler: preprocessor model, scoreboard queue fed at accept, monitor popping on output handshakes.
`timescale 1ns/1ps
module tb_amp_frame_scheduler;
  localparam int W = 6, D = 10, BIN_QTY = 12, TIMEOUT = 8;
  localparam int B  = W + D;
  localparam int FW = BIN_QTY * B;
  localparam int SW = B + $clog2(BIN_QTY);

  typedef struct packed {
    logic [FW-1:0] amps;
    logic [FW-1:0] fast;
    logic [SW-1:0] sum;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  amp_frame_scheduler_if #(.W(W), .D(D), .BIN_QTY(BIN_QTY)) bus ();
  amp_frame_scheduler #(.W(W), .D(D), .BIN_QTY(BIN_QTY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  resp_t       exp_q[$];
  logic [15:0] exp_cnt = '0;
  int          lat = 4;
  bit          pp_never = 1'b0;
  bit          rand_ready = 1'b0;
  bit          ready_level = 1'b1;

  // Preprocessor behaviour: XOR-scrambled bins, bin-reversed fast copy, plain sum of bins.
  function automatic resp_t ref_resp(input logic [FW-1:0] f);
    resp_t r;
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < BIN_QTY; i++) begin
      r.amps[i*B +: B] = f[i*B +: B] ^ B'(16'hA5C3);
      r.fast[i*B +: B] = f[(BIN_QTY-1-i)*B +: B];
      s = s + SW'(f[i*B +: B]);
    end
    r.sum = s;
    return r;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < FW / 32; k++) f[k*32 +: 32] = $urandom();
    return f;
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      tick();
      bus.out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  initial begin
    int            cnt;
    bit            active;
    logic [FW-1:0] held;
    resp_t         r;
    cnt = 0; active = 1'b0; held = '0;
    bus.pp_data_v_i = 1'b0; bus.pp_amps_i = '0; bus.pp_fast_i = '0; bus.pp_sum_i = '0;
    forever begin
      tick();
      bus.pp_data_v_i = 1'b0;
      if (active) begin
        cnt--;
        if (cnt == 0) begin
          active = 1'b0;
          chk("pp_amps_hold", bus.pp_amps_o, held);
          r = ref_resp(held);
          bus.pp_amps_i = r.amps;
          bus.pp_fast_i = r.fast;
          bus.pp_sum_i  = r.sum;
          bus.pp_data_v_i = 1'b1;
        end
      end
      if (bus.pp_start_o && rst) begin
        held   = bus.pp_amps_o;
        active = !pp_never;
        cnt    = lat;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("out_amps", bus.out_amps_o, e.amps);
        chk("out_fast", bus.out_fast_o, e.fast);
        chk("out_sum", bus.out_sum_o, e.sum);
      end
    end
  end

  task automatic send(input logic [FW-1:0] f, input bit expect_out);
    bit ok;
    ok = 1'b0;
    bus.in_amps_i  = f;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        ok = 1'b1;
        if (expect_out) begin
          exp_q.push_back(ref_resp(f));
          exp_cnt++;
        end
      end
      tick();
    end
    bus.in_valid_i = 1'b0;
    if (!ok) chk("accept_bound", 0, 1);
  endtask

  // which: 0 pp_start, 1 out_valid, 2 timeout_err, 3 scoreboard empty; at = cycle index of the hit
  task automatic wait_until(input int which, input int budget, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = bus.pp_start_o;
        1:       hit = bus.out_valid_o;
        2:       hit = bus.timeout_err_o;
        default: hit = (exp_q.size() == 0);
      endcase
      if (hit) at = cyc;
    end
    if (!hit) chk("wait_bound", which, 99);
  endtask

  task automatic drain_cnt(input string name);
    int at;
    wait_until(3, 2000, at);
    tick();
    @(negedge clk);
    chk(name, bus.frame_cnt_o, exp_cnt);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int            t0, at, at2;
    logic [FW-1:0] f;
    resp_t         r;
    bit            ok_v, ok_s, ok_r, any_v;
    bus.in_valid_i = 1'b0; bus.in_amps_i = '0; bus.err_clr_i = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_pp_start", bus.pp_start_o, 0);
    chk("rst_timeout_err", bus.timeout_err_o, 0);
    chk("rst_frame_cnt", bus.frame_cnt_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", bus.in_ready_o, 1);
    tick();

    // nominal frame, 4-cycle preprocessor
    lat = 4;
    f = {BIN_QTY{16'h0400}};
    t0 = cyc;
    send(f, 1'b1);
    wait_until(0, 20, at);
    chk("launch_cycle", at - t0, 1);
    @(negedge clk);
    chk("start_one_cycle", bus.pp_start_o, 0);
    wait_until(1, 20, at);
    chk("out_latency", at - t0, 6);
    drain_cnt("cnt_after_first");

    // preprocessor never answers
    pp_never = 1'b1;
    t0 = cyc;
    send(rand_frame(), 1'b0);
    wait_until(2, 40, at);
    chk("timeout_cycle", at - t0, 2 + TIMEOUT);
    chk("timeout_idle", bus.busy_o, 0);
    chk("timeout_in_ready", bus.in_ready_o, 1);
    chk("timeout_cnt", bus.frame_cnt_o, exp_cnt);
    tick(); tick();
    @(negedge clk);
    chk("timeout_sticky", bus.timeout_err_o, 1);
    tick();
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    @(negedge clk);
    chk("err_clr", bus.timeout_err_o, 0);
    tick();

    // clear held high across a new timeout
    bus.err_clr_i = 1'b1;
    t0 = cyc;
    send(rand_frame(), 1'b0);
    wait_until(2, 40, at);
    chk("set_beats_clr", at - t0, 2 + TIMEOUT);
    @(negedge clk);
    chk("clr_after_set", bus.timeout_err_o, 0);
    bus.err_clr_i = 1'b0;
    tick();
    pp_never = 1'b0;

    // answer on the last allowed WAIT cycle
    lat = TIMEOUT;
    t0 = cyc;
    send(rand_frame(), 1'b1);
    wait_until(1, 40, at);
    chk("edge_success_cycle", at - t0, 2 + TIMEOUT);
    chk("edge_no_err", bus.timeout_err_o, 0);
    drain_cnt("cnt_edge");

    // downstream stall in OUTPUT
    lat = 4;
    ready_level = 1'b0;
    tick(); tick();
    f = rand_frame();
    r = ref_resp(f);
    send(f, 1'b1);
    wait_until(1, 20, at);
    ok_v = 1'b1; ok_s = 1'b1; ok_r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b1) ok_v = 1'b0;
      if (bus.out_sum_o !== r.sum) ok_s = 1'b0;
`ifdef AMP_SCHED_SKID_EN
      if (bus.in_ready_o !== 1'b1) ok_r = 1'b0;
`else
      if (bus.in_ready_o !== 1'b0) ok_r = 1'b0;
`endif
    end
    chk("stall_valid_held", ok_v, 1);
    chk("stall_sum_stable", ok_s, 1);
    chk("stall_in_ready", ok_r, 1);
    ready_level = 1'b1;
    drain_cnt("cnt_after_stall");

    // reset in WAIT; the preprocessor answers late
    lat = 6;
    send(rand_frame(), 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_out_valid", bus.out_valid_o, 0);
    chk("midrst_frame_cnt", bus.frame_cnt_o, 0);
    chk("midrst_in_ready", bus.in_ready_o, 1);
    exp_cnt = '0;
    any_v = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid_o) any_v = 1'b1;
    end
    chk("late_data_ignored", any_v, 0);
    chk("late_data_cnt", bus.frame_cnt_o, exp_cnt);
    tick();

`ifdef AMP_SCHED_SKID_EN
    // back-to-back frames through the skid buffer
    lat = 4;
    send({BIN_QTY{16'h0400}}, 1'b1);
    t0 = cyc;
    send({BIN_QTY{16'h0800}}, 1'b1);
    chk("skid_accept_while_busy", cyc - t0, 1);
    chk("skid_busy", bus.busy_o, 1);
    wait_until(1, 20, at);
    tick();
    wait_until(0, 20, at2);
    chk("skid_relaunch", at2 - at, 2);
    drain_cnt("skid_cnt");
`endif

    // randomized traffic with random downstream backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      lat = $urandom_range(1, TIMEOUT);
      send(rand_frame(), 1'b1);
    end
    rand_ready  = 1'b0;
    ready_level = 1'b1;
    drain_cnt("cnt_random");

    // counter wrap: preload to 0xFFFF then deliver one more
    tick();
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    chk("cnt_preload", bus.frame_cnt_o, exp_cnt);
    tick();
    send(rand_frame(), 1'b1);
    drain_cnt("cnt_wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
